io_sequencer: RTL and testbench
===============================

Name: io_sequencer

Overview:
- Sequences the CPU's I/O instructions: stalls the PC on IN until a fresh debounced button press, then captures the switches.
- Latches the OUT register value for the 7-segment display and optionally holds the PC so each OUT stays visible.
- Tracks halt state.
- Sits between the UC (op_io, halt), the debouncer/switches, the register bank (write-back data) and the PC-select mux (stall).

Parameters:
DATA_WIDTH, 32, width of register/data words
SW_WIDTH, 18, width of the switch input (must be <= DATA_WIDTH)
OUT_HOLD, 2, number of stalled cycles per OUT instruction (0 = no stall)

Ports:
clock  input  1  system clock (the delayed CPU clock); all state updates on its rising edge
reset  input  1  synchronous, active-high reset
op_io  input  2  from UC: 00 none, 01 IN, 10 OUT, 11 reserved (treated as none)
halt  input  1  from UC: current instruction is HLT
button  input  1  debounced insert button, active-high level
switches  input  SW_WIDTH  board switches
data_out  input  DATA_WIDTH  register value to display (rt read port)
stall  output  1  1 = PC holds its current value (combinational)
read_data  output  DATA_WIDTH  captured switches, zero-extended, to write-back mux
read_valid  output  1  1 during the single cycle the IN instruction completes
disp_value  output  DATA_WIDTH  registered value driven to the display decoder
disp_update  output  1  one-cycle pulse, the cycle after disp_value changes
halted  output  1  1 once HLT has been executed

Behaviour:
- Reset (sync, priority over everything): state IDLE, hold counter 0. read_data, disp_value, read_valid, disp_update and halted are all 0. stall follows its combinational rule with state = IDLE.
- States: IDLE, WAIT_RELEASE, WAIT_PRESS, CAPTURE, OUT_HOLD, HALTED.
- IDLE:
  - op_io=01, button=1 -> WAIT_RELEASE. op_io=01, button=0 -> WAIT_PRESS. A held button never satisfies a new IN.
  - op_io=10 -> disp_value <= data_out at this edge. If OUT_HOLD>0: counter <= 1 and go to OUT_HOLD. Otherwise stay in IDLE.
  - halt=1 -> HALTED, halted <= 1.
  - op_io=00/11 with halt=0 -> stay.
- WAIT_RELEASE: button=0 -> WAIT_PRESS.
- WAIT_PRESS: button=1 -> CAPTURE, read_data <= zero-extended switches sampled at this edge.
- CAPTURE: read_valid=1, stall=0. The CPU writes read_data and advances the PC at the end of this cycle. Next state is IDLE.
- OUT_HOLD:
  - counter increments each cycle.
  - When counter == OUT_HOLD: stall=0, next state IDLE, counter <= 0.
  - Total cycles per OUT = OUT_HOLD+1 (OUT_HOLD stalled cycles plus 1 release cycle).
  - disp_value is not re-latched during the hold.
- HALTED: stall=1 permanently. Only reset exits.
- stall (combinational):
  - 1 when state is WAIT_RELEASE, WAIT_PRESS or HALTED.
  - 1 in IDLE when op_io=01, or when op_io=10 with OUT_HOLD>0, or when halt=1.
  - 1 in OUT_HOLD while counter < OUT_HOLD.
  - 0 otherwise (including the CAPTURE cycle).
- read_data holds its last captured value until the next capture; it is never cleared except by reset.
- disp_update = 1 for exactly the cycle after any IDLE->OUT latch. This applies even when the new value equals the old one.
- Abort: if op_io stops being 01 while in WAIT_RELEASE or WAIT_PRESS, return to IDLE. No capture, no read_valid.
- Back-to-back IN: CAPTURE -> IDLE sees the next IN. If the button is still held, go to WAIT_RELEASE. One press yields exactly one capture.
- Back-to-back OUT: each OUT gets a full OUT_HOLD+1 cycle window.
- halt and op_io!=00 simultaneously: halt wins.
- Reset mid-wait or mid-hold: immediate return to IDLE, no capture, disp_value cleared.

Test Plan:
- Reset, then IN with button=0, switches=18'h2A5F5; press button at cycle 5 -> stall=1 cycles 0-4. read_data=32'h0002A5F5 and read_valid=1 in the CAPTURE cycle, stall=0 in that cycle only.
- IN while button already held, then a second IN -> no capture until release followed by press. Two presses yield exactly two read_valid pulses with the matching switch values.
- OUT with data_out=32'hDEADBEEF, OUT_HOLD=2 -> disp_value=DEADBEEF the next cycle, disp_update pulses once. stall=1 for 2 cycles, 0 on the 3rd cycle. Repeat with OUT_HOLD=0 -> stall never asserted.
- HLT in IDLE -> halted=1 and stall=1 held for 100 cycles regardless of op_io/button. reset=1 for one cycle -> halted=0, stall=0 (op_io=00).
- Assert reset while in WAIT_PRESS with button rising in the same cycle -> no read_valid, read_data stays 0, next state IDLE.
- Drop op_io from 01 to 00 during WAIT_PRESS -> stall=0 the same cycle, IDLE the next cycle, no read_valid.

Source files
------------

// File: rtl/io_sequencer_if.sv
// Bus between the control unit / board I/O and the I/O sequencer.
// The master side drives the instruction and board inputs; the slave side is the sequencer.
interface io_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SW_WIDTH   = 18
);
  logic [1:0]            op_io;
  logic                  halt;
  logic                  button;
  logic [SW_WIDTH-1:0]   switches;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  stall;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic [DATA_WIDTH-1:0] disp_value;
  logic                  disp_update;
  logic                  halted;

  modport master (
    output op_io, halt, button, switches, data_out,
    input  stall, read_data, read_valid, disp_value, disp_update, halted
  );

  modport slave (
    input  op_io, halt, button, switches, data_out,
    output stall, read_data, read_valid, disp_value, disp_update, halted
  );
endinterface

// File: rtl/io_sequencer.sv
// Sequences IN/OUT/HLT instructions: stalls the PC for a fresh button press on IN,
// latches the display value on OUT (optionally holding the PC) and tracks halt state.
module io_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int SW_WIDTH   = 18,
  parameter int OUT_HOLD   = 2
) (
  input logic           clock,
  input logic           reset,
  io_sequencer_if.slave bus
);

  localparam logic [1:0] OP_IN  = 2'b01;
  localparam logic [1:0] OP_OUT = 2'b10;
  localparam int         CNT_W  = (OUT_HOLD < 1) ? 1 : $clog2(OUT_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(OUT_HOLD);
  localparam bit         HOLD_EN = (OUT_HOLD > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RELEASE,
    S_WAIT_PRESS,
    S_CAPTURE,
    S_OUT_HOLD,
    S_HALTED
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      hold_cnt;
  logic [DATA_WIDTH-1:0] read_data;
  logic [DATA_WIDTH-1:0] disp_value;
  logic                  read_valid;
  logic                  disp_update;
  logic                  halted;
  logic                  stall;
  logic                  is_in;
  logic                  is_out;

  assign is_in  = (bus.op_io == OP_IN);
  assign is_out = (bus.op_io == OP_OUT);

  // The wait states stall only while the IN is still being issued, so an abort
  // releases the PC in the same cycle.
  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:         stall = bus.halt || is_in || (is_out && HOLD_EN);
      S_WAIT_RELEASE: stall = is_in;
      S_WAIT_PRESS:   stall = is_in;
      S_OUT_HOLD:     stall = (hold_cnt != HOLD_MAX);
      S_HALTED:       stall = 1'b1;
      default:        stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      read_data   <= '0;
      disp_value  <= '0;
      read_valid  <= 1'b0;
      disp_update <= 1'b0;
      halted      <= 1'b0;
    end else begin
      read_valid  <= 1'b0;
      disp_update <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.halt) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else if (is_in) begin
            // A button already held must be released first so one press gives one capture
            state <= bus.button ? S_WAIT_RELEASE : S_WAIT_PRESS;
          end else if (is_out) begin
            disp_value  <= bus.data_out;
            disp_update <= 1'b1;
            if (HOLD_EN) begin
              hold_cnt <= CNT_W'(1);
              state    <= S_OUT_HOLD;
            end
          end
        end
        S_WAIT_RELEASE: begin
          if (!is_in)
            state <= S_IDLE;
          else if (!bus.button)
            state <= S_WAIT_PRESS;
        end
        S_WAIT_PRESS: begin
          if (!is_in) begin
            state <= S_IDLE;
          end else if (bus.button) begin
            state      <= S_CAPTURE;
            read_data  <= DATA_WIDTH'(bus.switches);
            read_valid <= 1'b1;
          end
        end
        S_CAPTURE: begin
          state <= S_IDLE;
        end
        S_OUT_HOLD: begin
          if (hold_cnt == HOLD_MAX) begin
            hold_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        S_HALTED: begin
          state  <= S_HALTED;
          halted <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall       = stall;
  assign bus.read_data   = read_data;
  assign bus.read_valid  = read_valid;
  assign bus.disp_value  = disp_value;
  assign bus.disp_update = disp_update;
  assign bus.halted      = halted;

endmodule

// File: tb/tb_io_sequencer.sv
// Directed bench for io_sequencer: one instance with OUT_HOLD=2 and one with OUT_HOLD=0
// share the same stimulus; expected values are hand-computed per cycle.
module tb_io_sequencer;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_IN   = 2'b01;
  localparam logic [1:0] OP_OUT  = 2'b10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compare_count  = 0;
  int   mismatch_count = 0;

  io_sequencer_if #(.DATA_WIDTH(32), .SW_WIDTH(18)) bus_a ();
  io_sequencer_if #(.DATA_WIDTH(32), .SW_WIDTH(18)) bus_b ();

  io_sequencer #(.DATA_WIDTH(32), .SW_WIDTH(18), .OUT_HOLD(2)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  io_sequencer #(.DATA_WIDTH(32), .SW_WIDTH(18), .OUT_HOLD(0)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [1:0] op, input logic hlt, input logic btn,
                               input logic [17:0] sw, input logic [31:0] dout);
    bus_a.op_io = op;  bus_a.halt = hlt; bus_a.button = btn;
    bus_a.switches = sw; bus_a.data_out = dout;
    bus_b.op_io = op;  bus_b.halt = hlt; bus_b.button = btn;
    bus_b.switches = sw; bus_b.data_out = dout;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(OP_NONE, 1'b0, 1'b0, 18'h0, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(OP_NONE, 1'b0, 1'b0, 18'h0, 32'h0);
    checkOutput("rst_stall",       32'(bus_a.stall),       32'd0);
    checkOutput("rst_read_data",   bus_a.read_data,        32'h0);
    checkOutput("rst_read_valid",  32'(bus_a.read_valid),  32'd0);
    checkOutput("rst_disp_value",  bus_a.disp_value,       32'h0);
    checkOutput("rst_disp_update", 32'(bus_a.disp_update), 32'd0);
    checkOutput("rst_halted",      32'(bus_a.halted),      32'd0);

    // reset in WAIT_PRESS while the button rises
    applyStimulus(OP_IN, 1'b0, 1'b0, 18'h15555, 32'h0);
    tick();
    checkOutput("wp_stall", 32'(bus_a.stall), 32'd1);
    reset = 1'b1;
    applyStimulus(OP_IN, 1'b0, 1'b1, 18'h15555, 32'h0);
    tick();
    reset = 1'b0;
    checkOutput("rstwp_valid", 32'(bus_a.read_valid), 32'd0);
    checkOutput("rstwp_data",  bus_a.read_data,       32'h0);
    applyStimulus(OP_NONE, 1'b0, 1'b0, 18'h0, 32'h0);
    checkOutput("rstwp_stall", 32'(bus_a.stall), 32'd0);
    tick();
    checkOutput("rstwp_valid2", 32'(bus_a.read_valid), 32'd0);
    checkOutput("rstwp_data2",  bus_a.read_data,       32'h0);

    // IN with button released, press arrives in cycle 5
    applyStimulus(OP_IN, 1'b0, 1'b0, 18'h2A5F5, 32'h0);
    checkOutput("in_stall_c0", 32'(bus_a.stall), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput($sformatf("in_stall_c%0d", i), 32'(bus_a.stall), 32'd1);
      checkOutput($sformatf("in_valid_c%0d", i), 32'(bus_a.read_valid), 32'd0);
    end
    applyStimulus(OP_IN, 1'b0, 1'b1, 18'h2A5F5, 32'h0);
    checkOutput("in_stall_c5", 32'(bus_a.stall), 32'd1);
    tick();
    checkOutput("cap_valid", 32'(bus_a.read_valid), 32'd1);
    checkOutput("cap_data",  bus_a.read_data,       32'h0002A5F5);
    checkOutput("cap_stall", 32'(bus_a.stall),      32'd0);
    applyStimulus(OP_NONE, 1'b0, 1'b0, 18'h0, 32'h0);
    tick();
    checkOutput("post_cap_valid", 32'(bus_a.read_valid), 32'd0);
    checkOutput("post_cap_data",  bus_a.read_data,       32'h0002A5F5);
    checkOutput("post_cap_stall", 32'(bus_a.stall),      32'd0);

    // IN with button already held, then back-to-back IN with button still held
    applyStimulus(OP_IN, 1'b0, 1'b1, 18'h00011, 32'h0);
    checkOutput("held_stall", 32'(bus_a.stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("held_no_valid", 32'(bus_a.read_valid), 32'd0);
      checkOutput("held_stall_w",  32'(bus_a.stall),      32'd1);
    end
    applyStimulus(OP_IN, 1'b0, 1'b0, 18'h00011, 32'h0);
    tick();
    checkOutput("rel_no_valid", 32'(bus_a.read_valid), 32'd0);
    applyStimulus(OP_IN, 1'b0, 1'b1, 18'h00011, 32'h0);
    tick();
    checkOutput("press1_valid", 32'(bus_a.read_valid), 32'd1);
    checkOutput("press1_data",  bus_a.read_data,       32'h00000011);
    applyStimulus(OP_IN, 1'b0, 1'b1, 18'h3FFFF, 32'h0);
    tick();
    checkOutput("b2b_idle_stall", 32'(bus_a.stall),      32'd1);
    checkOutput("b2b_idle_valid", 32'(bus_a.read_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("b2b_held_valid", 32'(bus_a.read_valid), 32'd0);
      checkOutput("b2b_held_data",  bus_a.read_data,       32'h00000011);
    end
    applyStimulus(OP_IN, 1'b0, 1'b0, 18'h3FFFF, 32'h0);
    tick();
    checkOutput("b2b_rel_valid", 32'(bus_a.read_valid), 32'd0);
    applyStimulus(OP_IN, 1'b0, 1'b1, 18'h3FFFF, 32'h0);
    tick();
    checkOutput("press2_valid", 32'(bus_a.read_valid), 32'd1);
    checkOutput("press2_data",  bus_a.read_data,       32'h0003FFFF);
    applyStimulus(OP_NONE, 1'b0, 1'b0, 18'h0, 32'h0);
    tick();
    checkOutput("press2_after", 32'(bus_a.read_valid), 32'd0);

    // OUT with hold (dut_a) and without hold (dut_b)
    applyStimulus(OP_OUT, 1'b0, 1'b0, 18'h0, 32'hDEADBEEF);
    checkOutput("out_a_stall_c0", 32'(bus_a.stall), 32'd1);
    checkOutput("out_b_stall_c0", 32'(bus_b.stall), 32'd0);
    tick();
    checkOutput("out_a_disp_c1",  bus_a.disp_value,       32'hDEADBEEF);
    checkOutput("out_a_upd_c1",   32'(bus_a.disp_update), 32'd1);
    checkOutput("out_a_stall_c1", 32'(bus_a.stall),       32'd1);
    checkOutput("out_b_disp_c1",  bus_b.disp_value,       32'hDEADBEEF);
    checkOutput("out_b_upd_c1",   32'(bus_b.disp_update), 32'd1);
    checkOutput("out_b_stall_c1", 32'(bus_b.stall),       32'd0);
    applyStimulus(OP_OUT, 1'b0, 1'b0, 18'h0, 32'h12345678);
    tick();
    checkOutput("out_a_disp_c2",  bus_a.disp_value,       32'hDEADBEEF);
    checkOutput("out_a_upd_c2",   32'(bus_a.disp_update), 32'd0);
    checkOutput("out_a_stall_c2", 32'(bus_a.stall),       32'd0);
    checkOutput("out_b_disp_c2",  bus_b.disp_value,       32'h12345678);
    checkOutput("out_b_stall_c2", 32'(bus_b.stall),       32'd0);
    tick();
    checkOutput("out2_a_stall_c0", 32'(bus_a.stall),       32'd1);
    checkOutput("out2_a_upd_c0",   32'(bus_a.disp_update), 32'd0);
    tick();
    checkOutput("out2_a_disp_c1",  bus_a.disp_value,       32'h12345678);
    checkOutput("out2_a_upd_c1",   32'(bus_a.disp_update), 32'd1);
    checkOutput("out2_a_stall_c1", 32'(bus_a.stall),       32'd1);
    tick();
    checkOutput("out2_a_stall_c2", 32'(bus_a.stall),       32'd0);
    checkOutput("out2_a_upd_c2",   32'(bus_a.disp_update), 32'd0);
    applyStimulus(OP_NONE, 1'b0, 1'b0, 18'h0, 32'h0);
    tick();
    checkOutput("out_idle_stall", 32'(bus_a.stall), 32'd0);
    applyStimulus(OP_OUT, 1'b0, 1'b0, 18'h0, 32'h12345678);
    tick();
    checkOutput("out_same_upd",  32'(bus_a.disp_update), 32'd1);
    checkOutput("out_same_disp", bus_a.disp_value,       32'h12345678);
    tick();
    applyStimulus(OP_NONE, 1'b0, 1'b0, 18'h0, 32'h0);
    tick();

    // abort an IN while waiting for the press
    applyStimulus(OP_IN, 1'b0, 1'b0, 18'h00ABC, 32'h0);
    tick();
    checkOutput("abort_wait_stall", 32'(bus_a.stall), 32'd1);
    applyStimulus(OP_NONE, 1'b0, 1'b1, 18'h00ABC, 32'h0);
    checkOutput("abort_stall_now", 32'(bus_a.stall), 32'd0);
    tick();
    checkOutput("abort_valid", 32'(bus_a.read_valid), 32'd0);
    checkOutput("abort_data",  bus_a.read_data,       32'h0003FFFF);
    applyStimulus(OP_OUT, 1'b0, 1'b0, 18'h0, 32'hA5A5A5A5);
    tick();
    checkOutput("abort_idle_upd", 32'(bus_a.disp_update), 32'd1);
    tick();
    applyStimulus(OP_NONE, 1'b0, 1'b0, 18'h0, 32'h0);
    tick();

    // HLT together with OUT: halt wins
    applyStimulus(OP_OUT, 1'b1, 1'b0, 18'h0, 32'hFFFFFFFF);
    checkOutput("hlt_stall_c0", 32'(bus_a.stall), 32'd1);
    tick();
    checkOutput("hlt_halted", 32'(bus_a.halted),      32'd1);
    checkOutput("hlt_no_upd", 32'(bus_a.disp_update), 32'd0);
    checkOutput("hlt_disp",   bus_a.disp_value,       32'hA5A5A5A5);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(2'(i), 1'b0, 1'((i >> 2) & 1), 18'(i), 32'(i));
      checkOutput("hlt_hold_stall", 32'(bus_a.stall), 32'd1);
      tick();
      checkOutput("hlt_hold_halted", 32'(bus_a.halted), 32'd1);
    end
    reset = 1'b1;
    applyStimulus(OP_NONE, 1'b0, 1'b0, 18'h0, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("hlt_rst_halted", 32'(bus_a.halted), 32'd0);
    checkOutput("hlt_rst_stall",  32'(bus_a.stall),  32'd0);
    checkOutput("hlt_rst_disp",   bus_a.disp_value,  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
